// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared state, mode and requester definitions for the LED scheduler
package led_sched_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        MODE_RR     = 2'b00,
        MODE_PRIO   = 2'b01,
        MODE_FREEZE = 2'b10,
        MODE_LAMP   = 2'b11
    } sched_mode_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_scheduler_if.sv
// rtl/led_scheduler_if.sv - requester/LED bundle between the scheduler and its requesters
interface led_scheduler_if;

    logic [led_sched_pkg::NUM_REQ-1:0]   req;
    logic [4*led_sched_pkg::NUM_REQ-1:0] pattern;
    logic [3:0]                          led;
    logic [led_sched_pkg::NUM_REQ-1:0]   grant;
    logic                                busy;

    modport master (output req, pattern, input led, grant, busy);
    modport slave  (input req, pattern, output led, grant, busy);

endinterface

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way arbiter, round-robin or fixed lowest-index priority
module rr_arbiter4
    import led_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_owner,
    input  sched_mode_t        mode,
    output logic [NUM_REQ-1:0] winner
);

    logic [1:0] cand;

    // Descending loops so the highest-priority candidate is assigned last and wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        if (mode == MODE_PRIO) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                cand = 2'(i);
                if (req[cand]) begin
                    winner = 4'b0001 << cand;
                end
            end
        end else begin
            // k == NUM_REQ lands back on the last owner, so a lone repeat requester still wins.
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand = last_owner + 2'(k);
                if (req[cand]) begin
                    winner = 4'b0001 << cand;
                end
            end
        end
    end

endmodule

// File: rtl/led_scheduler.sv
// rtl/led_scheduler.sv - time-slices four LED requesters with dwell and blanking gap
module led_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100000000,
    parameter int unsigned GAP_CYCLES   = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      sw,
    led_scheduler_if.slave  bus
);

    logic [1:0]         sw_meta;
    sched_mode_t        mode;
    sched_state_t       state;
    logic [31:0]        cnt;
    logic [1:0]         last_owner;
    logic [NUM_REQ-1:0] grant_q;
    logic [3:0]         led_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] winner;
    logic [NUM_REQ-1:0] next_owner;
    logic [1:0]         owner_idx;
    logic [3:0]         led_nxt;
    logic               busy_nxt;
    logic               owner_dropped;
    logic               dwell_done;
    logic               gap_done;
    logic               can_grant;
    logic               take_grant;
    logic               keep_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= 2'b00;
            mode    <= MODE_RR;
        end else begin
            sw_meta <= sw;
            mode    <= sched_mode_t'(sw_meta);
        end
    end

    rr_arbiter4 u_arb (
        .req        (bus.req),
        .last_owner (last_owner),
        .mode       (mode),
        .winner     (winner)
    );

    assign owner_dropped = (bus.req & grant_q) == '0;
    assign dwell_done    = cnt == DWELL_CYCLES - 32'd1;
    assign gap_done      = cnt == GAP_CYCLES - 32'd1;
    assign can_grant     = (bus.req != '0) && (mode != MODE_FREEZE);
    assign take_grant    = can_grant && ((state == ST_IDLE) || (state == ST_GAP && gap_done));
    assign keep_grant    = (state == ST_GRANT) && !owner_dropped
                           && ((mode == MODE_FREEZE) || !dwell_done);

    // led is aligned with grant: it shows the slice of whoever owns the LEDs after this edge.
    always_comb begin
        next_owner = '0;
        if (take_grant) begin
            next_owner = winner;
        end else if (keep_grant) begin
            next_owner = grant_q;
        end
        owner_idx = onehot_to_idx(next_owner);
        led_nxt   = 4'h0;
        if (mode == MODE_LAMP) begin
            led_nxt = 4'hF;
        end else if (next_owner != '0) begin
            led_nxt = bus.pattern[4*owner_idx +: 4];
        end
        busy_nxt = take_grant || (state == ST_GRANT) || (state == ST_GAP && !gap_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_owner <= 2'd3;
            grant_q    <= '0;
            led_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_grant) begin
                        state <= ST_GRANT;
                        cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (keep_grant) begin
                        if (mode != MODE_FREEZE) begin
                            cnt <= cnt + 32'd1;
                        end
                    end else begin
                        state <= ST_GAP;
                        cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state <= take_grant ? ST_GRANT : ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
            if (take_grant) begin
                last_owner <= onehot_to_idx(winner);
            end
            grant_q <= next_owner;
            led_q   <= led_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign bus.led   = led_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_scheduler.sv
// tb/tb_led_scheduler.sv - randomized and directed checks of led_scheduler against a behavioural model
module tb_led_scheduler;

    localparam int unsigned DWELL = 4;
    localparam int unsigned GAP   = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] sw    = 2'b00;

    led_scheduler_if bus ();

    led_scheduler #(
        .DWELL_CYCLES (DWELL),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns the LEDs, how long they have held them, how much blanking is left.
    int         m_owner;
    int         m_last;
    int         m_held;
    int         m_gap_left;
    logic [1:0] m_meta;
    logic [1:0] m_mode;
    logic [3:0] m_led;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last, input logic [1:0] md);
        if (md == 2'b01) begin
            for (int i = 0; i < 4; i++) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_held = 0; m_gap_left = 0;
        m_meta = 2'b00; m_mode = 2'b00; m_led = 4'h0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [15:0] p, input logic [1:0] s);
        bit arb;
        arb = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1; m_gap_left = GAP;
            end else if (m_mode != 2'b10) begin
                if (m_held == DWELL - 1) begin
                    m_owner = -1; m_gap_left = GAP;
                end else begin
                    m_held++;
                end
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            arb = (m_gap_left == 0);
        end else begin
            arb = 1'b1;
        end
        if (arb && r != 4'h0 && m_mode != 2'b10) begin
            m_owner = pick(r, m_last, m_mode);
            m_last  = m_owner;
            m_held  = 0;
        end
        if (m_mode == 2'b11)   m_led = 4'hF;
        else if (m_owner >= 0) m_led = p[4*m_owner +: 4];
        else                   m_led = 4'h0;
        m_mode = m_meta;
        m_meta = s;
    endtask

    task automatic compare_model();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("led", 32'(bus.led), 32'(m_led));
        check("grant", 32'(bus.grant), 32'(eg));
        check("busy", 32'(bus.busy), 32'((m_owner >= 0) || (m_gap_left > 0)));
        check("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    endtask

    task automatic tick(input logic [3:0] r, input logic [15:0] p, input logic [1:0] s);
        bus.req = r; bus.pattern = p; sw = s;
        model_step(r, p, s);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_led", 32'(bus.led), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  r;
        logic [15:0] p;
        logic [1:0]  s;
        bus.req = 4'h0; bus.pattern = 16'h0;
        #1 rst_n = 1'b0;
        #1;
        check("init_led", 32'(bus.led), 32'd0);
        check("init_grant", 32'(bus.grant), 32'd0);
        check("init_busy", 32'(bus.busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin over all four, 4 cycles each, 2 blank cycles between owners.
        p = 16'h4321;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick(4'hF, p, 2'b00);
                check("rr_grant", 32'(bus.grant), 32'(4'b0001 << (k % 4)));
                check("rr_led", 32'(bus.led), 32'(k % 4 + 1));
            end
            if (k < 4) begin
                for (int c = 0; c < 2; c++) begin
                    tick(4'hF, p, 2'b00);
                    check("rr_gap", 32'(bus.grant), 32'd0);
                end
            end
        end

        // Fixed priority with req=1010 always picks index 1.
        do_reset();
        tick(4'h0, p, 2'b01);
        tick(4'h0, p, 2'b01);
        tick(4'hA, p, 2'b01);
        check("prio_first", 32'(bus.grant), 32'h2);
        for (int c = 0; c < 20; c++) begin
            tick(4'hA, p, 2'b01);
            check("prio_steady", 32'(bus.grant == 4'h0 || bus.grant == 4'h2), 32'd1);
        end

        // Owner 0 drops at dwell count 1, requester 2 wins after the gap.
        do_reset();
        tick(4'h1, p, 2'b00);
        check("drop_g0", 32'(bus.grant), 32'h1);
        tick(4'h1, p, 2'b00);
        tick(4'h4, p, 2'b00);
        check("drop_gap", 32'(bus.grant), 32'h0);
        check("drop_busy", 32'(bus.busy), 32'd1);
        tick(4'h4, p, 2'b00);
        tick(4'h4, p, 2'b00);
        check("drop_next", 32'(bus.grant), 32'h4);

        // Lamp test three cycles after the switch, pattern returns after leaving it.
        do_reset();
        p = 16'h000A;
        tick(4'h1, p, 2'b00);
        check("lamp_pre", 32'(bus.led), 32'hA);
        tick(4'h1, p, 2'b11);
        tick(4'h1, p, 2'b11);
        check("lamp_wait", 32'(bus.led), 32'hA);
        tick(4'h1, p, 2'b11);
        check("lamp_on", 32'(bus.led), 32'hF);
        tick(4'h1, p, 2'b00);
        check("lamp_gap", 32'(bus.led), 32'hF);
        tick(4'h1, p, 2'b00);
        tick(4'h1, p, 2'b00);
        check("lamp_off", 32'(bus.led), 32'hA);
        check("lamp_regrant", 32'(bus.grant), 32'h1);

        // Freeze mid-grant holds the owner past DWELL; release finishes the count.
        do_reset();
        tick(4'h1, p, 2'b00);
        tick(4'h1, p, 2'b00);
        tick(4'h1, p, 2'b10);
        tick(4'h1, p, 2'b10);
        for (int c = 0; c < 10; c++) begin
            tick(4'h1, p, 2'b10);
            check("frz_hold", 32'(bus.grant), 32'h1);
        end
        tick(4'h1, p, 2'b00);
        tick(4'h1, p, 2'b00);
        check("frz_tail", 32'(bus.grant), 32'h1);
        tick(4'h1, p, 2'b00);
        check("frz_gap", 32'(bus.grant), 32'h0);

        // Reset in the middle of owner 1's grant, then restart from index 0.
        do_reset();
        for (int c = 0; c < 8; c++) tick(4'hF, p, 2'b00);
        check("rstmid_owner", 32'(bus.grant), 32'h2);
        do_reset();
        tick(4'hF, p, 2'b00);
        check("rstmid_first", 32'(bus.grant), 32'h1);

        // Random traffic against the model.
        r = 4'h0;
        s = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0)   r = 4'($urandom);
            if ($urandom_range(0, 39) == 0)  s = 2'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            p = 16'($urandom);
            tick(r, p, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_scheduler.md
LED_SCHEDULER -- requirements
Module: led_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 100000000, meaning the number of clk cycles one requester owns the LEDs (range 2 .. 2^32-1).
REQ-002 SHALL have parameter GAP_CYCLES, default 1000000, meaning the number of clk cycles the LEDs are blanked between owners (range 1 .. 2^32-1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port sw, input, 2 bits: asynchronous mode select (00 round-robin, 01 fixed priority, 10 freeze, 11 lamp test).
REQ-006 SHALL have port req, input, 4 bits: per-requester request, synchronous to clk.
REQ-007 SHALL have port pattern, input, 16 bits: requester i drives LED pattern pattern[4i+3:4i].
REQ-008 SHALL have port led, output, 4 bits: registered LED drive.
REQ-009 SHALL have port grant, output, 4 bits: one-hot current owner, or zero.
REQ-010 SHALL have port busy, output, 1 bit: high in state GRANT or GAP.

Function
REQ-011 SHALL pass sw through a 2-flop synchronizer; "mode" below means the synchronized value.
REQ-012 SHALL implement states IDLE, GRANT and GAP.
REQ-013 In IDLE with req nonzero, SHALL select a winner, enter GRANT, and assert grant one cycle after req is first sampled high.
REQ-014 Round-robin (mode 00): the winner SHALL be the first requesting index after the last owner, wrapping 3->0; after reset the search SHALL start at index 0.
REQ-015 Fixed priority (mode 01): the winner SHALL be the lowest requesting index.
REQ-016 In GRANT, led SHALL equal the owner's pattern slice, registered with 1-cycle latency.
REQ-017 In GRANT, a 32-bit dwell counter SHALL count from 0.
REQ-018 When the dwell counter reaches DWELL_CYCLES-1, the FSM SHALL enter GAP.
REQ-019 If the owner deasserts req during GRANT, the FSM SHALL enter GAP on the next cycle regardless of the dwell count.
REQ-020 In GAP, led and grant SHALL be 0; after GAP_CYCLES cycles the FSM SHALL arbitrate, entering GRANT if req is nonzero and IDLE otherwise.
REQ-021 If the only requester is the previous owner, the round-robin search SHALL wrap to it and re-grant it.
REQ-022 Freeze (mode 10): the dwell counter SHALL hold and the owner SHALL keep the LEDs while it requests.
REQ-023 Under freeze, owner req deassertion SHALL still apply REQ-019.
REQ-024 Under freeze in IDLE or GAP, no new grant SHALL be issued.
REQ-025 Lamp test (mode 11): led SHALL be 4'b1111 from the cycle after the synchronized mode changes.
REQ-026 Lamp test SHALL override the led output only; FSM, grant and counters SHALL continue as for mode 00.
REQ-027 Mode changes between 00, 01 and 10 SHALL take effect at the next arbitration or counter update; no in-progress grant SHALL be pre-empted.
REQ-028 Requests from non-owners arriving in GRANT or GAP SHALL be serviced at the next arbitration only; no requests SHALL be latched or queued.
REQ-029 grant SHALL be one-hot or zero in every cycle.

Reset
REQ-030 On rst_n low, the FSM SHALL asynchronously enter IDLE and led, grant and busy SHALL go to 0.
REQ-031 On rst_n low, the counters SHALL clear, the round-robin pointer SHALL reset to index 3 (so index 0 searches first), and the synchronizer flops SHALL clear to 00.
REQ-032 Reset asserted mid-GRANT or mid-GAP SHALL abort without completing the current dwell or gap.
REQ-033 Reset deassertion SHALL be synchronized externally; the block relies on its synchronous release.

Structure
REQ-034 State encoding, mode encodings and requester count (4) SHALL reside in shared package led_sched_pkg.
REQ-035 Arbitration SHALL be a combinational sub-module rr_arbiter4 (inputs req, last owner, mode; output one-hot winner), reusable elsewhere.
REQ-036 The dwell and gap timers SHALL share one 32-bit counter.

Verification
REQ-037 Scenario: DWELL=4, GAP=2, mode 00, req=4'b1111 -> grant sequence 0001,0010,0100,1000,0001; 4 cycles each, separated by 2 blank cycles.
REQ-038 Scenario: mode 01, req=4'b1010 steady -> grant always 0010.
REQ-039 Scenario: owner 0 deasserts req at dwell count 1 -> GAP next cycle, then a grant to the next requester.
REQ-040 Scenario: pattern slice 0 = 4'hA, owner 0, switch to mode 11 -> led=4'hF three cycles later; return to 00 -> led=4'hA.
REQ-041 Scenario: mode 10 entered mid-GRANT -> the owner holds the LEDs beyond DWELL cycles; return to 00 -> GAP after the remaining count.
REQ-042 Scenario: rst_n pulsed low mid-GRANT -> led=0, grant=0 and busy=0 immediately (asynchronously); with req=4'b1111 after release, the first grant is 0001.
